// File: rtl/ov7670_pkg.sv
// OV7670 SCCB sender shared types and constants.
// State encoding, frame length and the default camera write ID.
package ov7670_pkg;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    START,
    BITS,
    STOP,
    GAP,
    DONE
  } sccb_state_t;

  localparam int SCCB_FRAME_BITS = 27;
  localparam logic [7:0] OV7670_DEVICE_ID = 8'h42;

endpackage

// File: rtl/sccb_qtr_tick.sv
// Quarter-period strobe generator for the SCCB bus.
// Restarts whenever clr is high so every FSM state begins on a full quarter.
module sccb_qtr_tick #(
  parameter int QTR = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (QTR < 2) ? 1 : $clog2(QTR);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(QTR - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ov7670_sccb_sender.sv
// Walks a register table and writes each entry to the OV7670 over SCCB.
// Three-phase write frames: device ID, register address, register value.
module ov7670_sccb_sender
  import ov7670_pkg::*;
#(
  parameter int          CLK_HZ        = 25_000_000,
  parameter int          SCCB_HZ       = 100_000,
  parameter logic [7:0]  DEVICE_ID     = OV7670_DEVICE_ID,
  parameter int          INIT_WAIT_CYC = 1_000_000,
  parameter int          GAP_QTR       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] command,
  input  logic        finished,
  output logic        advance,
  output logic        sioc,
  output logic        siod,
  output logic        config_done
);

  localparam int QTR = CLK_HZ / (4 * SCCB_HZ);

  generate
    if (QTR < 2) begin : g_bad_qtr
      $error("ov7670_sccb_sender: quarter period below 2 cycles");
    end
    if (GAP_QTR < 1 || GAP_QTR > 255) begin : g_bad_gap
      $error("ov7670_sccb_sender: GAP_QTR outside 1..255");
    end
  endgenerate

  sccb_state_t state, state_nx;

  logic        tick;
  logic        bit_end;
  logic [7:0]  q;
  logic [4:0]  bit_cnt;
  logic [26:0] shift;
  logic [31:0] wait_cnt;

  sccb_qtr_tick #(
    .QTR(QTR)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_nx != state),
    .tick (tick)
  );

  assign bit_end = (state == BITS) && tick && (q == 8'd3);

  always_comb begin
    state_nx = state;
    unique case (state)
      WAIT_INIT:
        if (wait_cnt == 32'(INIT_WAIT_CYC - 1)) state_nx = IDLE;
      IDLE:
        state_nx = finished ? DONE : START;
      START:
        if (tick && q == 8'd1) state_nx = BITS;
      BITS:
        if (bit_end && bit_cnt == 5'(SCCB_FRAME_BITS - 1))
          state_nx = STOP;
      STOP:
        if (tick && q == 8'd2) state_nx = GAP;
      GAP:
        if (tick && q == 8'(GAP_QTR - 1)) state_nx = IDLE;
      DONE:
        state_nx = DONE;
      default:
        state_nx = WAIT_INIT;
    endcase
  end

  always_comb begin
    sioc        = 1'b1;
    siod        = 1'b1;
    advance     = 1'b0;
    config_done = 1'b0;
    unique case (state)
      START: siod = (q == 8'd0);
      BITS: begin
        sioc = q[1];
        siod = shift[26];
      end
      STOP: begin
        sioc    = (q != 8'd0);
        siod    = (q == 8'd2);
        advance = tick && (q == 8'd2);
      end
      DONE: config_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT_INIT;
      q        <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) q <= '0;
      else if (bit_end) q <= '0;
      else if (tick) q <= q + 8'd1;
      if (state == WAIT_INIT) wait_cnt <= wait_cnt + 32'd1;
      if (state == IDLE) bit_cnt <= '0;
      else if (bit_end) bit_cnt <= bit_cnt + 5'd1;
      // ACK slots are driven high; the slave's ACK is never sampled
      if (state == IDLE && !finished)
        shift <= {DEVICE_ID, 1'b1, command[15:8], 1'b1,
                  command[7:0], 1'b1};
      else if (bit_end)
        shift <= {shift[25:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_sender.sv
// Bench for ov7670_sccb_sender: waveform model per table entry,
// cycle-by-cycle bus compare, plus literal timing and bit-stream pins.
module tb_ov7670_sccb_sender;

  localparam int QTR = 4;
  localparam logic [7:0] DEV = 8'h42;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] command;
  logic        finished;
  logic        advance, sioc, siod, config_done;

  logic [15:0] tbl [0:7];
  logic [2:0]  idx;
  logic [15:0] tcmd;
  logic        ovr = 1'b0;

  logic [3:0]  exp_q [$];
  logic        chk = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  int          mcyc, rises, hi_tog, adv_cnt, rises_at_adv;
  int          first_fall, first_adv, first_done;
  logic [26:0] frame_bits;
  logic        p_c, p_d;

  always #5 clk = ~clk;

  ov7670_sccb_sender #(
    .CLK_HZ(400),
    .SCCB_HZ(25),
    .DEVICE_ID(8'h42),
    .INIT_WAIT_CYC(10),
    .GAP_QTR(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .command(command),
    .finished(finished),
    .advance(advance),
    .sioc(sioc),
    .siod(siod),
    .config_done(config_done)
  );

  // register table: index steps on advance, data one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      tcmd <= '0;
    end else begin
      if (advance) idx <= idx + 3'd1;
      tcmd <= tbl[idx];
    end
  end

  assign command  = ovr ? 16'h3A14 : tcmd;
  assign finished = (tcmd == 16'hFFFF);

  task automatic chk_eq(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push(input bit c, input bit d, input bit a,
                      input bit dn, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({c, d, a, dn});
  endtask

  // expected bus per cycle from release: wait, then one frame per entry
  task automatic build();
    logic [26:0] b;
    push(1, 1, 0, 0, 10);
    for (int i = 0; i < 8; i++) begin
      push(1, 1, 0, 0, 1);
      if (tbl[i] == 16'hFFFF) begin
        push(1, 1, 0, 1, 20);
        break;
      end
      b = {DEV, 1'b1, tbl[i][15:8], 1'b1, tbl[i][7:0], 1'b1};
      push(1, 1, 0, 0, QTR);
      push(1, 0, 0, 0, QTR);
      for (int k = 26; k >= 0; k--) begin
        push(0, b[k], 0, 0, 2 * QTR);
        push(1, b[k], 0, 0, 2 * QTR);
      end
      push(0, 0, 0, 0, QTR);
      push(1, 0, 0, 0, QTR);
      push(1, 1, 0, 0, QTR - 1);
      push(1, 1, 1, 0, 1);
      push(1, 1, 0, 0, QTR);
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst_n) begin
      cyc = 0;
    end else if (chk && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({sioc, siod, advance, config_done} !== e) begin
        errors++;
        $display("FAIL bus cyc=%0d got=%b want=%b (sioc,siod,adv,done)",
                 cyc, {sioc, siod, advance, config_done}, e);
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mcyc = 0; rises = 0; hi_tog = 0; adv_cnt = 0; rises_at_adv = -1;
      first_fall = -1; first_adv = -1; first_done = -1;
      frame_bits = '0; p_c = 1'b1; p_d = 1'b1;
    end else if (chk) begin
      if (!p_c && sioc) begin
        rises++;
        if (rises <= 27) frame_bits = {frame_bits[25:0], siod};
      end
      if (p_c && sioc && siod != p_d) hi_tog++;
      if (p_c && sioc && p_d && !siod && first_fall < 0) first_fall = mcyc;
      if (advance) begin
        adv_cnt++;
        if (first_adv < 0) begin
          first_adv = mcyc;
          rises_at_adv = rises;
        end
      end
      if (config_done && first_done < 0) first_done = mcyc;
      p_c = sioc;
      p_d = siod;
      mcyc++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    chk = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_bus", int'({sioc, siod, advance, config_done}), 4'b1100);
    build();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk = 1'b1;
  endtask

  task automatic drain(input int ovr_at);
    for (int i = 0; i < 4000 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (i == ovr_at) ovr = 1'b1;
      if (i == ovr_at + 100) ovr = 1'b0;
    end
    chk_eq("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    tbl[0] = 16'h1280; tbl[1] = 16'h1100; tbl[2] = 16'h3344;
    for (int i = 3; i < 8; i++) tbl[i] = 16'hFFFF;

    // three entries, command override mid-frame of 0x1100
    do_reset();
    drain(600);
    chk_eq("start_fall_cyc", first_fall, 15);
    chk_eq("first_adv_cyc", first_adv, 462);
    chk_eq("frame_cycles", first_adv - 11 + 1, 452);
    chk_eq("rises_incl_stop", rises_at_adv, 28);
    chk_eq("frame1_bits", int'(frame_bits),
           int'({8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1}));
    chk_eq("adv_count", adv_cnt, 3);
    chk_eq("hi_toggles", hi_tog, 6);
    chk_eq("done_bus", int'({sioc, siod, config_done}), 3'b111);

    // reset during bit 13 of the first frame
    do_reset();
    repeat (230) @(negedge clk);
    chk_eq("pre_rst_sioc", int'(sioc), 0);
    #1 rst_n = 1'b0;
    #1 chk_eq("async_rst_bus",
              int'({sioc, siod, advance, config_done}), 4'b1100);
    do_reset();
    drain(-1);
    chk_eq("rst2_first_adv", first_adv, 462);
    chk_eq("rst2_bits", int'(frame_bits),
           int'({8'h42, 1'b1, 8'h12, 1'b1, 8'h80, 1'b1}));
    chk_eq("rst2_adv_count", adv_cnt, 3);

    // table already exhausted at first IDLE
    tbl[0] = 16'hFFFF;
    do_reset();
    drain(-1);
    chk_eq("empty_adv_count", adv_cnt, 0);
    chk_eq("empty_done_cyc", first_done, 11);
    chk_eq("empty_done", int'(config_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
